// File: rtl/rat_pkg.sv
// rat_pkg: shared parameters and types for the register alias table.
//   XLEN     data width
//   ROBID_W  ROB tag width
//   NAREGS   number of architectural registers (x0 hardwired zero)
//   RD_NONE  rename destination code meaning "no destination"
//   rat_entry_t  per-register rename state {busy, ready, tag, value}
package rat_pkg;

    localparam int XLEN    = 32;
    localparam int ROBID_W = 7;
    localparam int NAREGS  = 32;
    localparam int AREG_W  = $clog2(NAREGS);

    localparam logic [5:0] RD_NONE = 6'b100000;

    typedef struct packed {
        logic               busy;   // a younger in-flight producer owns this reg
        logic               ready;  // that producer's result has been written back
        logic [ROBID_W-1:0] tag;    // ROB tag of that producer
        logic [XLEN-1:0]    value;  // speculative result, meaningful when ready
    } rat_entry_t;

    // A pending source is handed to rename as its zero-extended ROB tag.
    function automatic logic [XLEN-1:0] tag_to_word(input logic [ROBID_W-1:0] t);
        return {{(XLEN-ROBID_W){1'b0}}, t};
    endfunction

endpackage

// File: rtl/rat_regfile.sv
// rat_regfile: architectural (committed) register file.
//   clk, rst        clock; asynchronous active-low reset clears every register
//   we/waddr/wdata  single write port; writes to x0 are dropped
//   raddr0/rdata0   combinational read port 0 (x0 reads zero)
//   raddr1/rdata1   combinational read port 1 (x0 reads zero)
module rat_regfile
    import rat_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AREG_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [AREG_W-1:0] raddr0,
    output logic [XLEN-1:0]   rdata0,
    input  logic [AREG_W-1:0] raddr1,
    output logic [XLEN-1:0]   rdata1
);

    logic [XLEN-1:0] regs [NAREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NAREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata0 = (raddr0 == '0) ? '0 : regs[raddr0];
    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];

endmodule

// File: rtl/rat.sv
// rat: register alias table plus architectural register file.
// Answers rename's two source lookups with either a value or a ROB tag,
// tracks in-flight producers per arch reg, and absorbs writeback, commit
// and flush from the back end.
//
// Optional feature: define RAT_PERF_EN to add perf_lookups and
// perf_tag_lookups (32-bit wrapping counters).
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   rename_rat_valid/rd/robid     lookup request and optional allocation
//   rename_rat_rs1/rs2            source arch regs to look up
//   rat_rs{1,2}_valid/tagval      registered lookup result (value or tag)
//   wb_valid/robid/result         writeback bus
//   rob_commit_valid/rd/robid/value  in-order retirement
//   rob_flush                     squash every speculative mapping
//
// Handshake: all inputs are single-cycle qualified pulses with no
// backpressure. rename_rat_valid high means rs1/rs2 are sampled at this
// edge and the answer appears on rat_rs*_* after it, holding until the next
// valid lookup; wb_valid and rob_commit_valid likewise qualify their
// payloads for exactly the cycle they are high.
module rat
    import rat_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rename_rat_valid,
    input  logic [5:0]         rename_rat_rd,
    input  logic [ROBID_W-1:0] rename_rat_robid,
    input  logic [AREG_W-1:0]  rename_rat_rs1,
    input  logic [AREG_W-1:0]  rename_rat_rs2,
    output logic               rat_rs1_valid,
    output logic [XLEN-1:0]    rat_rs1_tagval,
    output logic               rat_rs2_valid,
    output logic [XLEN-1:0]    rat_rs2_tagval,
    input  logic               wb_valid,
    input  logic [ROBID_W-1:0] wb_robid,
    input  logic [XLEN-1:0]    wb_result,
    input  logic               rob_commit_valid,
    input  logic [AREG_W-1:0]  rob_commit_rd,
    input  logic [ROBID_W-1:0] rob_commit_robid,
    input  logic [XLEN-1:0]    rob_commit_value,
    input  logic               rob_flush
`ifdef RAT_PERF_EN
    ,
    output logic [31:0]        perf_lookups,
    output logic [31:0]        perf_tag_lookups
`endif
);

    rat_entry_t ent   [NAREGS];
    rat_entry_t ent_n [NAREGS];

    logic [AREG_W-1:0] src_rs   [2];
    logic [XLEN-1:0]   arch_val [2];
    logic              src_v    [2];
    logic [XLEN-1:0]   src_val  [2];

    logic alloc;

    assign src_rs[0] = rename_rat_rs1;
    assign src_rs[1] = rename_rat_rs2;

    // x0 is never renamed; rd[5] marks an instruction without a destination.
    assign alloc = rename_rat_valid && !rename_rat_rd[5] && (rename_rat_rd[4:0] != '0);

    rat_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rob_commit_valid),
        .waddr  (rob_commit_rd),
        .wdata  (rob_commit_value),
        .raddr0 (rename_rat_rs1),
        .rdata0 (arch_val[0]),
        .raddr1 (rename_rat_rs2),
        .rdata1 (arch_val[1])
    );

    // Lookup mux. It reads the pre-edge mapping, so an instruction's own
    // allocation never aliases its sources. Same-cycle commit and writeback
    // are forwarded so the answer is not one cycle stale.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_v[s]   = 1'b0;
            src_val[s] = '0;
            if (src_rs[s] == '0) begin
                src_v[s]   = 1'b1;
                src_val[s] = '0;
            end else if (!ent[src_rs[s]].busy) begin
                src_v[s]   = 1'b1;
                src_val[s] = (rob_commit_valid && (rob_commit_rd == src_rs[s]))
                             ? rob_commit_value : arch_val[s];
            end else if (ent[src_rs[s]].ready) begin
                src_v[s]   = 1'b1;
                src_val[s] = ent[src_rs[s]].value;
            end else if (wb_valid && (wb_robid == ent[src_rs[s]].tag)) begin
                src_v[s]   = 1'b1;
                src_val[s] = wb_result;
            end else begin
                src_v[s]   = 1'b0;
                src_val[s] = tag_to_word(ent[src_rs[s]].tag);
            end
        end
    end

    // Entry next state. Later statements win: writeback, then commit
    // busy-clear, then allocation, then flush over everything.
    always_comb begin
        ent_n = ent;
        for (int i = 1; i < NAREGS; i++) begin
            if (wb_valid && ent[i].busy && !ent[i].ready && (ent[i].tag == wb_robid)) begin
                ent_n[i].ready = 1'b1;
                ent_n[i].value = wb_result;
            end
            // A newer allocation carries a different tag and so stays busy.
            if (rob_commit_valid && (rob_commit_rd == AREG_W'(i)) &&
                ent[i].busy && (ent[i].tag == rob_commit_robid)) begin
                ent_n[i].busy  = 1'b0;
                ent_n[i].ready = 1'b0;
            end
            if (alloc && (rename_rat_rd[4:0] == AREG_W'(i))) begin
                ent_n[i].busy  = 1'b1;
                ent_n[i].ready = 1'b0;
                ent_n[i].tag   = rename_rat_robid;
            end
            if (rob_flush) begin
                ent_n[i].busy  = 1'b0;
                ent_n[i].ready = 1'b0;
            end
        end
        ent_n[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NAREGS; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NAREGS; i++) begin
                ent[i] <= ent_n[i];
            end
        end
    end

    // Registered lookup result. A flush invalidates whatever rename saw this
    // cycle, so the outputs are forced to "tag 0, not valid".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rat_rs1_valid  <= 1'b0;
            rat_rs1_tagval <= '0;
            rat_rs2_valid  <= 1'b0;
            rat_rs2_tagval <= '0;
        end else if (rob_flush) begin
            rat_rs1_valid  <= 1'b0;
            rat_rs1_tagval <= '0;
            rat_rs2_valid  <= 1'b0;
            rat_rs2_tagval <= '0;
        end else if (rename_rat_valid) begin
            rat_rs1_valid  <= src_v[0];
            rat_rs1_tagval <= src_val[0];
            rat_rs2_valid  <= src_v[1];
            rat_rs2_tagval <= src_val[1];
        end
    end

`ifdef RAT_PERF_EN
    // A source counts as a tag lookup when the value it returns is not
    // valid (flush-forced results included); x0 always returns a value.
    logic [1:0] tag_hits;

    always_comb begin
        tag_hits = '0;
        for (int s = 0; s < 2; s++) begin
            if (src_rs[s] != '0 && (rob_flush || !src_v[s])) begin
                tag_hits[s] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lookups     <= '0;
            perf_tag_lookups <= '0;
        end else if (rename_rat_valid) begin
            perf_lookups     <= perf_lookups + 32'd1;
            perf_tag_lookups <= perf_tag_lookups + 32'(tag_hits[0]) + 32'(tag_hits[1]);
        end
    end
`endif

endmodule
